// File: rtl/upower_pkg.sv
// Shared uPower definitions: instruction field positions, primary opcodes and the
// fetch-stage state encoding. Used by the fetch stage and the control unit.
package upower_pkg;

    localparam int INSTR_W  = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int XOX_MSB    = 10;
    localparam int XOX_LSB    = 1;
    localparam int XOXO_MSB   = 9;
    localparam int XOXO_LSB   = 1;
    localparam int XODS_MSB   = 1;
    localparam int XODS_LSB   = 0;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int XOX_W    = XOX_MSB - XOX_LSB + 1;
    localparam int XOXO_W   = XOXO_MSB - XOXO_LSB + 1;
    localparam int XODS_W   = XODS_MSB - XODS_LSB + 1;

    localparam logic [OPCODE_W-1:0] OP_XFORM = 6'd31;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd14;
    localparam logic [OPCODE_W-1:0] OP_ADDIS = 6'd15;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd28;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'd24;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'd26;
    localparam logic [OPCODE_W-1:0] OP_LD    = 6'd58;
    localparam logic [OPCODE_W-1:0] OP_LWZ   = 6'd32;
    localparam logic [OPCODE_W-1:0] OP_LHZ   = 6'd40;
    localparam logic [OPCODE_W-1:0] OP_LHA   = 6'd42;
    localparam logic [OPCODE_W-1:0] OP_LBZ   = 6'd34;
    localparam logic [OPCODE_W-1:0] OP_STB   = 6'd38;
    localparam logic [OPCODE_W-1:0] OP_STH   = 6'd44;
    localparam logic [OPCODE_W-1:0] OP_STWU  = 6'd37;
    localparam logic [OPCODE_W-1:0] OP_STW   = 6'd36;
    localparam logic [OPCODE_W-1:0] OP_STD   = 6'd62;
    localparam logic [OPCODE_W-1:0] OP_B     = 6'd18;
    localparam logic [OPCODE_W-1:0] OP_BC    = 6'd19;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic opcode_is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_XFORM, OP_ADDI, OP_ADDIS, OP_ANDI, OP_ORI, OP_XORI,
            OP_LD, OP_LWZ, OP_LHZ, OP_LHA, OP_LBZ,
            OP_STB, OP_STH, OP_STWU, OP_STW, OP_STD,
            OP_B, OP_BC:  opcode_is_legal = 1'b1;
            default:      opcode_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/upower_instr_fields.sv
// Combinational splitter of a uPower instruction word into its XO fields.
// With FETCH_ILLEGAL_OP_EN defined it also flags opcodes outside the supported set.
module upower_instr_fields
    import upower_pkg::*;
(
    input  logic [INSTR_W-1:0]  instr,
    output logic [INSTR_W-1:0]  word,
    output logic [OPCODE_W-1:0] opcode,
    output logic [XOX_W-1:0]    xox,
    output logic [XOXO_W-1:0]   xoxo,
    output logic [XODS_W-1:0]   xods,
    output logic                illegal
);

    // The full word is forwarded so consumers can take word and fields from one place.
    assign word   = instr;
    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign xox    = instr[XOX_MSB:XOX_LSB];
    assign xoxo   = instr[XOXO_MSB:XOXO_LSB];
    assign xods   = instr[XODS_MSB:XODS_LSB];

`ifdef FETCH_ILLEGAL_OP_EN
    assign illegal = ~opcode_is_legal(instr[OPCODE_MSB:OPCODE_LSB]);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/upower_fetch_stage.sv
// uPower instruction fetch: PC, req/ack memory requests, output register with
// valid/ready and branch redirect squashing. Optional macro: FETCH_ILLEGAL_OP_EN.
module upower_fetch_stage
    import upower_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSTR_W-1:0]  dec_instr,
    output logic [PC_W-1:0]     dec_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [XOX_W-1:0]    xox,
    output logic [XOXO_W-1:0]   xoxo,
    output logic [XODS_W-1:0]   xods,
    output logic                illegal_op
);

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               dec_valid_q, dec_valid_d;
    logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
    logic [PC_W-1:0]    dec_pc_q, dec_pc_d;

    logic               ack_fire;
    logic [PC_W-1:0]    target;
    logic               instr_illegal;

    assign ack_fire = imem_ack & req_q;
    assign target   = redirect_pc & ALIGN_MASK;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d        = target;
                    dec_valid_d = 1'b0;
                    req_d       = 1'b1;
                    // With nothing outstanding there is no ack to wait for.
                    if (ack_fire || !req_q) begin
                        state_d = ST_FETCH;
                        addr_d  = target;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (ack_fire) begin
                    dec_instr_d = imem_rdata;
                    dec_pc_d    = pc_q;
                    dec_valid_d = 1'b1;
                    pc_d        = pc_q + PC_STEP;
                    req_d       = 1'b0;
                    state_d     = ST_HOLD;
                end else begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d        = target;
                    dec_valid_d = 1'b0;
                    req_d       = 1'b1;
                    addr_d      = target;
                    state_d     = ST_FETCH;
                end else if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    req_d       = 1'b1;
                    addr_d      = pc_q;
                    state_d     = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d        = target;
                    dec_valid_d = 1'b0;
                end
                if (ack_fire) begin
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    upower_instr_fields u_fields (
        .instr   (dec_instr_q),
        .word    (dec_instr),
        .opcode  (opcode),
        .xox     (xox),
        .xoxo    (xoxo),
        .xods    (xods),
        .illegal (instr_illegal)
    );

    // Decoded from the registered word; gating with valid clears it with the handshake.
    assign illegal_op = dec_valid_q & instr_illegal;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign dec_valid = dec_valid_q;
    assign dec_pc    = dec_pc_q;

endmodule

// File: tb/tb_upower_fetch_stage.sv
// Directed bench for upower_fetch_stage with a latency-programmable memory responder.
`timescale 1ns/1ps
module tb_upower_fetch_stage;

    localparam int              PC_W   = 64;
    localparam logic [PC_W-1:0] RST_PC = 64'h100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [PC_W-1:0] dec_pc;
    logic [5:0]      opcode;
    logic [9:0]      xox;
    logic [8:0]      xoxo;
    logic [1:0]      xods;
    logic            illegal_op;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int              mem_lat   = 1;
    int              mem_cnt   = 0;
    int              proto_err = 0;
    logic [PC_W-1:0] last_addr;
    logic [PC_W-1:0] ovr_addr  = '1;
    logic [31:0]     ovr_word  = 32'h0;

    always #5 clk = ~clk;

    upower_fetch_stage #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .opcode         (opcode),
        .xox            (xox),
        .xoxo           (xoxo),
        .xods           (xods),
        .illegal_op     (illegal_op)
    );

    // Default memory image: addi (opcode 14) with the low address bits as immediate.
    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        if (a == ovr_addr) return ovr_word;
        return 32'h3800_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory responder: acks mem_lat cycles after a request first appears.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        last_addr  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                mem_cnt    = 0;
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (imem_ack || mem_cnt == 0) begin
                    mem_cnt = 1;
                end else begin
                    mem_cnt++;
                    if (imem_addr !== last_addr) proto_err++;
                end
                if (imem_addr[1:0] !== 2'b00) proto_err++;
                last_addr  = imem_addr;
                imem_ack   = (mem_cnt > mem_lat);
                imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step(); step();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== '0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else pass_cnt++;
        total_cnt++; if (dec_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", dec_valid); else pass_cnt++;
        total_cnt++; if (dec_instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", dec_instr); else pass_cnt++;
        total_cnt++; if (dec_pc !== '0) $display("FAIL rst_pc got=%h exp=0", dec_pc); else pass_cnt++;
        total_cnt++; if ({opcode, xox, xoxo, xods} !== 27'h0) $display("FAIL rst_fields got=%h exp=0", {opcode, xox, xoxo, xods}); else pass_cnt++;
        total_cnt++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal got=%b exp=0", illegal_op); else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) $display("FAIL rst_first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); else pass_cnt++;
    endtask

    task automatic test_sequence();
        logic [PC_W-1:0] exp_pc;
        mem_lat = 1; dec_ready = 1'b1;
        apply_reset();
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_pc = RST_PC + PC_W'(4 * ((c - 1) / 3));
            if ((c - 1) % 3 != 2) begin
                total_cnt++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) $display("FAIL seq_req cyc=%0d got=%b/%h exp=1/%h", c, imem_req, imem_addr, exp_pc); else pass_cnt++;
                total_cnt++; if (dec_valid !== 1'b0) $display("FAIL seq_valid_low cyc=%0d got=%b exp=0", c, dec_valid); else pass_cnt++;
            end else begin
                $display("txn seq pc=%h instr=%h", dec_pc, dec_instr);
                total_cnt++; if (dec_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL seq_valid cyc=%0d got=%b/%b exp=1/0", c, dec_valid, imem_req); else pass_cnt++;
                total_cnt++; if (dec_pc !== exp_pc || dec_instr !== (32'h3800_0000 | {16'h0, exp_pc[15:0]})) $display("FAIL seq_data cyc=%0d got=%h/%h exp_pc=%h", c, dec_pc, dec_instr, exp_pc); else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        mem_lat = 1; dec_ready = 1'b0;
        ovr_addr = RST_PC; ovr_word = 32'h7C22_1A14;
        apply_reset();
        step(); step(); step();
        $display("txn stall pc=%h instr=%h", dec_pc, dec_instr);
        for (int c = 0; c < 6; c++) begin
            total_cnt++; if (dec_valid !== 1'b1 || dec_instr !== 32'h7C22_1A14 || dec_pc !== RST_PC) $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/7c221a14/%h", c, dec_valid, dec_instr, dec_pc, RST_PC); else pass_cnt++;
            total_cnt++; if (opcode !== 6'd31 || xox !== 10'd266 || xoxo !== 9'd266 || xods !== 2'd0) $display("FAIL stall_fields c=%0d got=%0d/%0d/%0d/%0d exp=31/266/266/0", c, opcode, xox, xoxo, xods); else pass_cnt++;
            total_cnt++; if (imem_req !== 1'b0) $display("FAIL stall_noreq c=%0d got=%b exp=0", c, imem_req); else pass_cnt++;
            if (c == 5) dec_ready = 1'b1;
            step();
        end
        total_cnt++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC + 64'h4) $display("FAIL stall_release got=%b/%b/%h exp=0/1/%h", dec_valid, imem_req, imem_addr, RST_PC + 64'h4); else pass_cnt++;
        ovr_addr = '1;
    endtask

    task automatic test_drain();
        int shown_104;
        shown_104 = 0;
        mem_lat = 3; dec_ready = 1'b1;
        apply_reset();
        for (int c = 1; c <= 14; c++) begin
            step();
            redirect_valid = 1'b0;
            if (dec_valid === 1'b1 && dec_pc === RST_PC + 64'h4) shown_104++;
            if (c == 7) begin redirect_valid = 1'b1; redirect_pc = 64'h2003; end
            if (c == 8 || c == 9) begin
                total_cnt++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 64'h4) $display("FAIL drain_addr cyc=%0d got=%b/%h exp=1/%h", c, imem_req, imem_addr, RST_PC + 64'h4); else pass_cnt++;
            end
            if (c >= 6 && c <= 13) begin
                total_cnt++; if (dec_valid !== 1'b0) $display("FAIL drain_valid cyc=%0d got=%b exp=0", c, dec_valid); else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000) $display("FAIL drain_target got=%b/%h exp=1/2000", imem_req, imem_addr); else pass_cnt++;
            end
            if (c == 14) begin
                $display("txn drain pc=%h instr=%h", dec_pc, dec_instr);
                total_cnt++; if (dec_valid !== 1'b1 || dec_pc !== 64'h2000 || dec_instr !== 32'h3800_2000) $display("FAIL drain_deliver got=%b/%h/%h exp=1/2000/38002000", dec_valid, dec_pc, dec_instr); else pass_cnt++;
            end
        end
        total_cnt++; if (shown_104 !== 0) $display("FAIL drain_squash got=%0d exp=0", shown_104); else pass_cnt++;
    endtask

    task automatic test_redirect_ack();
        mem_lat = 1; dec_ready = 1'b1;
        apply_reset();
        step(); step();
        total_cnt++; if (imem_ack !== 1'b1) $display("FAIL rack_setup got=%b exp=1", imem_ack); else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        step();
        redirect_valid = 1'b0;
        total_cnt++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h3000) $display("FAIL rack_drop got=%b/%b/%h exp=0/1/3000", dec_valid, imem_req, imem_addr); else pass_cnt++;
        step(); step();
        $display("txn rack pc=%h instr=%h", dec_pc, dec_instr);
        total_cnt++; if (dec_valid !== 1'b1 || dec_pc !== 64'h3000 || dec_instr !== 32'h3800_3000) $display("FAIL rack_deliver got=%b/%h/%h exp=1/3000/38003000", dec_valid, dec_pc, dec_instr); else pass_cnt++;
        // Redirect coinciding with the consuming handshake.
        redirect_valid = 1'b1; redirect_pc = 64'h405;
        step();
        redirect_valid = 1'b0;
        total_cnt++; if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h404) $display("FAIL hold_redirect got=%b/%b/%h exp=0/1/404", dec_valid, imem_req, imem_addr); else pass_cnt++;
        step(); step();
        total_cnt++; if (dec_valid !== 1'b1 || dec_pc !== 64'h404) $display("FAIL hold_redirect_deliver got=%b/%h exp=1/404", dec_valid, dec_pc); else pass_cnt++;
    endtask

    task automatic test_reset_in_hold();
        mem_lat = 1; dec_ready = 1'b0;
        apply_reset();
        step(); step(); step();
        total_cnt++; if (dec_valid !== 1'b1) $display("FAIL rhold_setup got=%b exp=1", dec_valid); else pass_cnt++;
        rst_n = 1'b0;
        step();
        total_cnt++; if ({imem_req, dec_valid, illegal_op} !== 3'b000 || imem_addr !== '0 || dec_pc !== '0 || dec_instr !== 32'h0 || opcode !== 6'd0) $display("FAIL rhold_clear got=%b%b%b/%h/%h/%h exp=000/0/0/0", imem_req, dec_valid, illegal_op, imem_addr, dec_pc, dec_instr); else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) $display("FAIL rhold_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); else pass_cnt++;
        step(); step();
        total_cnt++; if (dec_valid !== 1'b1 || dec_pc !== RST_PC) $display("FAIL rhold_deliver got=%b/%h exp=1/%h", dec_valid, dec_pc, RST_PC); else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic exp_ill;
`ifdef FETCH_ILLEGAL_OP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        mem_lat = 1; dec_ready = 1'b0;
        ovr_addr = RST_PC; ovr_word = 32'h0400_0000;
        apply_reset();
        step(); step(); step();
        $display("txn illegal pc=%h instr=%h", dec_pc, dec_instr);
        total_cnt++; if (dec_valid !== 1'b1 || opcode !== 6'd1 || illegal_op !== exp_ill) $display("FAIL ill_op1 got=%b/%0d/%b exp=1/1/%b", dec_valid, opcode, illegal_op, exp_ill); else pass_cnt++;
        dec_ready = 1'b1;
        step();
        total_cnt++; if (dec_valid !== 1'b0 || illegal_op !== 1'b0) $display("FAIL ill_clear got=%b/%b exp=0/0", dec_valid, illegal_op); else pass_cnt++;
        dec_ready = 1'b0;
        step(); step();
        total_cnt++; if (dec_valid !== 1'b1 || opcode !== 6'd14 || illegal_op !== 1'b0) $display("FAIL ill_op14 got=%b/%0d/%b exp=1/14/0", dec_valid, opcode, illegal_op); else pass_cnt++;
        ovr_addr = '1;
    endtask

    initial begin
        rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequence();
        test_stall();
        test_drain();
        test_redirect_ack();
        test_reset_in_hold();
        test_illegal();
        total_cnt++; if (proto_err !== 0) $display("FAIL protocol got=%0d exp=0", proto_err); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/upower_fetch_stage.md
Name: upower_fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the uPower control unit.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Holds each fetched instruction in an output register, split into the opcode/xox/xoxo/xods fields the control unit consumes, behind a valid/ready handshake.
- Accepts branch redirects from execute, squashing wrong-path fetches.

Parameters:
- PC_W, 64: program counter / instruction address width.
- RESET_PC, 0: PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; low 2 bits always 0.
- imem_ack  in  1  instruction memory returns data this cycle.
- imem_rdata  in  32  instruction word, qualified by imem_ack.
- redirect_valid  in  1  taken branch; load redirect_pc.
- redirect_pc  in  PC_W  branch target.
- dec_valid  out  1  output register holds a valid instruction.
- dec_ready  in  1  downstream accepts the instruction.
- dec_instr  out  32  registered instruction word.
- dec_pc  out  PC_W  address of dec_instr.
- opcode  out  6  dec_instr[31:26].
- xox  out  10  dec_instr[10:1] (X-form XO).
- xoxo  out  9  dec_instr[9:1] (XO-form XO).
- xods  out  2  dec_instr[1:0] (DS-form XO).
- illegal_op  out  1  see Optional Feature.

Behaviour:
- Reset (rst_n low at a clock edge): pc=RESET_PC, state=FETCH; imem_req=0, imem_addr=0, dec_valid=0, dec_instr=0, dec_pc=0, illegal_op=0. The first request is issued in the cycle after rst_n rises. Reset mid-transaction abandons any outstanding request; instruction memory is reset on the same rst_n.
- Memory protocol: once raised, imem_req stays high with imem_addr stable until the cycle imem_ack=1. imem_ack is never in the same cycle req first rises; minimum latency is 1 cycle. imem_ack without imem_req is ignored.
- States: FETCH, HOLD, DRAIN.
- FETCH: imem_req=1, imem_addr=pc.
  - On ack: dec_instr<=imem_rdata, dec_pc<=pc, dec_valid<=1, pc<=pc+4 (wraps modulo 2^PC_W), go to HOLD.
- HOLD: imem_req=0; outputs stable while dec_valid && !dec_ready.
  - On dec_ready: dec_valid<=0, go to FETCH.
  - Peak throughput is 1 instruction per 3 cycles at 1-cycle memory latency.
- DRAIN: imem_req stays high with the stale address; the ack is consumed, data discarded, then go to FETCH (pc already holds the target).
- Redirect: redirect_valid has priority over all other events in the same cycle. pc<={redirect_pc[PC_W-1:2],2'b00}; dec_valid<=0 next cycle.
  - In FETCH with no ack this cycle: go to DRAIN.
  - In FETCH with ack this cycle: data discarded, go to FETCH.
  - In HOLD or DRAIN: go to FETCH, or stay in DRAIN if its ack has not arrived.
- Redirect in the same cycle as dec_ready: the handshake completes (instruction consumed), then the redirect applies.
- Field outputs are combinational slices of the dec_instr register; they are 0 after reset.
- No instruction is ever presented twice or dropped except by redirect.

Optional Feature:
- Macro FETCH_ILLEGAL_OP_EN.
- When defined: illegal_op is registered alongside dec_instr. It is 1 when the opcode is not in {31,14,15,28,24,26,58,32,40,42,34,38,44,37,36,62,18,19}. It is cleared with dec_valid.
- When undefined: illegal_op is tied to 0 and no comparator logic is built.

Decomposition:
- Shared package upower_pkg holds:
  - opcode constants (OP_XFORM=31, OP_B=18, OP_BC=19, load/store/ALU-immediate opcodes);
  - field bit-position localparams;
  - the fetch state encoding;
  - the INSTR_W=32 constant.
- One natural sub-module: upower_instr_fields, a combinational splitter (instr -> opcode/xox/xoxo/xods, plus the legal-opcode check under FETCH_ILLEGAL_OP_EN). The control unit's testbench reuses it.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle memory latency, dec_ready=1 -> imem_addr sequence 0x100,0x104,0x108; dec_pc matches; dec_valid pulses every 3 cycles.
- Ack returns 0x7C221A14 (opcode 31), dec_ready=0 for 5 cycles -> dec_valid, dec_instr and fields (opcode=31, xox=266, xoxo=266) stay stable; no new imem_req until dec_ready=1.
- Redirect to 0x2003 while a request to 0x104 is outstanding with 3-cycle latency -> DRAIN holds addr 0x104 until ack; data discarded; next request addr 0x2000; dec_valid never shows the 0x104 word.
- Redirect in the same cycle as ack -> data dropped, dec_valid=0; next cycle imem_addr=target.
- Pull rst_n low during HOLD with dec_valid=1 -> next cycle all outputs 0 and pc=RESET_PC; the first request follows rst_n release.
- With FETCH_ILLEGAL_OP_EN, fetch 0x04000000 (opcode 1) -> illegal_op=1 with dec_valid; opcode 14 -> illegal_op=0. Without the macro -> illegal_op=0 always.
